// File: rtl/trig_param_bank.sv
// Bank of 32-bit parameter slots. Each slot is written either straight to the active
// bank or to a shadow copy that is applied on a later tick.
module trig_param_bank #(
    parameter int unsigned          NPARAM   = 16,
    parameter logic [NPARAM*32-1:0] DEFAULTS = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPARAM-1:0]      trig,
    input  logic [15:0]            data_lo,
    input  logic [15:0]            data_hi,
    input  logic                   mode,
    input  logic                   commit,
    input  logic                   tick,
    input  logic                   soft_clr,
    input  logic [4:0]             rd_sel,
    input  logic                   rd_shadow,
    output logic [NPARAM*32-1:0]   params,
    output logic [31:0]            rd_data,
    output logic                   pending,
    output logic [NPARAM-1:0]      dirty,
    output logic                   upd
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEL_W  = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                         state_q;
    logic [NPARAM-1:0][WORD_W-1:0]  shadow_q, shadow_d;
    logic [NPARAM-1:0][WORD_W-1:0]  active_q, active_d;
    logic [NPARAM-1:0][WORD_W-1:0]  def_bank;
    logic [NPARAM-1:0]              dirty_q, dirty_d;
    logic                           upd_q, upd_d;
    logic [WORD_W-1:0]              rd_q, rd_d;
    logic [WORD_W-1:0]              word;
    logic                           apply;

    assign def_bank = DEFAULTS;
    assign word     = {data_hi, data_lo};

    // A tick applies staged data when armed, or in the same edge as a fresh commit.
    assign apply = !soft_clr && tick && ((state_q == ARMED) || commit);

    // Slot update: staged apply first, then this edge's load, so a coincident trig
    // re-stages the new word while the old shadow goes live.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        upd_d    = 1'b0;
        if (soft_clr) begin
            shadow_d = def_bank;
            active_d = def_bank;
            dirty_d  = '0;
            upd_d    = 1'b1;
        end else begin
            if (apply && (|dirty_q)) begin
                upd_d = 1'b1;
            end
            for (int unsigned i = 0; i < NPARAM; i++) begin
                if (apply && dirty_q[i]) begin
                    active_d[i] = shadow_q[i];
                    dirty_d[i]  = 1'b0;
                end
                if (trig[i]) begin
                    shadow_d[i] = word;
                    if (mode) begin
                        dirty_d[i] = 1'b1;
                    end else begin
                        active_d[i] = word;
                        dirty_d[i]  = 1'b0;
                        upd_d       = 1'b1;
                    end
                end
            end
        end
    end

    // Readback mux; indices beyond the bank read as zero.
    always_comb begin
        rd_d = '0;
        for (int unsigned i = 0; i < NPARAM; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_d = rd_shadow ? shadow_q[i] : active_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (soft_clr) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (commit && !tick) state_q <= ARMED;
                ARMED:   if (tick)            state_q <= IDLE;
                default:                      state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= def_bank;
            active_q <= def_bank;
            dirty_q  <= '0;
            upd_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            upd_q    <= upd_d;
            rd_q     <= rd_d;
        end
    end

    assign params  = active_q;
    assign pending = (state_q == ARMED);
    assign dirty   = dirty_q;
    assign upd     = upd_q;
    assign rd_data = rd_q;

endmodule

// File: tb/tb_trig_param_bank.sv
// Directed scoreboard bench for trig_param_bank: stimulus queues expected values per
// cycle, a negedge monitor compares them and tracks every upd pulse.
module tb_trig_param_bank;

    localparam int unsigned NP = 8;
    localparam logic [NP*32-1:0] DEF = {32'hD0000007, 32'hD0000006, 32'hD0000005, 32'hD0000004,
                                        32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

    localparam int K_PARAM   = 0;
    localparam int K_PENDING = 1;
    localparam int K_DIRTY   = 2;
    localparam int K_RD      = 3;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     trig;
    logic [15:0]       data_lo;
    logic [15:0]       data_hi;
    logic              mode;
    logic              commit;
    logic              tick;
    logic              soft_clr;
    logic [4:0]        rd_sel;
    logic              rd_shadow;
    logic [NP*32-1:0]  params;
    logic [31:0]       rd_data;
    logic              pending;
    logic [NP-1:0]     dirty;
    logic              upd;

    trig_param_bank #(.NPARAM(NP), .DEFAULTS(DEF)) dut (
        .clk(clk), .reset(reset), .trig(trig), .data_lo(data_lo), .data_hi(data_hi),
        .mode(mode), .commit(commit), .tick(tick), .soft_clr(soft_clr),
        .rd_sel(rd_sel), .rd_shadow(rd_shadow), .params(params), .rd_data(rd_data),
        .pending(pending), .dirty(dirty), .upd(upd)
    );

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   updq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int kind, input int idx,
                             input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc + dc; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic expect_upd(input int dc);
        updq.push_back(cyc + dc);
    endtask

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_PARAM:   return params[idx*32 +: 32];
            K_PENDING: return {31'b0, pending};
            K_DIRTY:   return {31'b0, dirty[idx]};
            K_RD:      return rd_data;
            default:   return 32'h0;
        endcase
    endfunction

    // Monitor: compare all expectations due this cycle, and account for each upd pulse.
    always @(negedge clk) begin : mon
        int          i;
        int          w;
        logic [31:0] got;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].cyc == cyc) begin
                got = actual(sbq[i].kind, sbq[i].idx);
                checks++;
                if (got !== sbq[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sbq[i].name, cyc, got, sbq[i].val);
                end
                sbq.delete(i);
            end else begin
                i++;
            end
        end
        if (upd === 1'b1) begin
            checks++;
            if (updq.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected cyc=%0d got=1 want=0", cyc);
            end else begin
                w = updq.pop_front();
                if (w != cyc) begin
                    errors++;
                    $display("FAIL upd_timing cyc=%0d got=%0d want=%0d", cyc, cyc, w);
                end
            end
        end else if (updq.size() > 0 && updq[0] <= cyc) begin
            checks++;
            errors++;
            w = updq.pop_front();
            $display("FAIL upd_missing cyc=%0d got=0 want=1 (due cyc %0d)", cyc, w);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; trig = '0; data_lo = '0; data_hi = '0; mode = 1'b0; commit = 1'b0;
        tick = 1'b0; soft_clr = 1'b0; rd_sel = '0; rd_shadow = 1'b0;

        // Reset state
        step();
        expect_at(0, K_PARAM, 0, 32'hD0000000, "rst_slot0");
        expect_at(0, K_PARAM, 4, 32'hD0000004, "rst_slot4");
        expect_at(0, K_PENDING, 0, 32'h0, "rst_pending");
        expect_at(0, K_RD, 0, 32'h0, "rst_rd");
        expect_at(0, K_DIRTY, 3, 32'h0, "rst_dirty3");
        step();
        reset = 1'b0;
        step();

        // Immediate write to slot 3
        mode = 1'b0; data_hi = 16'h3F80; data_lo = 16'h0000; trig = 8'h08;
        expect_at(1, K_PARAM, 3, 32'h3F800000, "imm_slot3");
        expect_at(1, K_DIRTY, 3, 32'h0, "imm_dirty3");
        expect_upd(1);
        step();
        trig = '0;
        step();

        // Staged write to slot 1, commit, tick later
        mode = 1'b1; data_hi = 16'h42A0; data_lo = 16'h0000; trig = 8'h02;
        expect_at(1, K_DIRTY, 1, 32'h1, "stg_dirty1_set");
        expect_at(1, K_PARAM, 1, 32'hD0000001, "stg_slot1_hold");
        step();
        trig = '0; commit = 1'b1;
        expect_at(1, K_PENDING, 0, 32'h1, "stg_pending_arm");
        step();
        commit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_at(1, K_PARAM, 1, 32'hD0000001, "stg_slot1_wait");
            expect_at(1, K_PENDING, 0, 32'h1, "stg_pending_wait");
            step();
        end
        tick = 1'b1;
        expect_at(1, K_PARAM, 1, 32'h42A00000, "stg_slot1_apply");
        expect_at(1, K_DIRTY, 1, 32'h0, "stg_dirty1_clr");
        expect_at(1, K_PENDING, 0, 32'h0, "stg_pending_clr");
        expect_upd(1);
        step();
        tick = 1'b0;
        step();

        // Commit and tick together
        data_hi = 16'h1234; data_lo = 16'h5678; trig = 8'h01;
        expect_at(1, K_DIRTY, 0, 32'h1, "ct_dirty0_set");
        step();
        trig = '0; commit = 1'b1; tick = 1'b1;
        expect_at(0, K_PENDING, 0, 32'h0, "ct_pending_pre");
        expect_at(1, K_PARAM, 0, 32'h12345678, "ct_slot0");
        expect_at(1, K_DIRTY, 0, 32'h0, "ct_dirty0_clr");
        expect_at(1, K_PENDING, 0, 32'h0, "ct_pending_post");
        expect_upd(1);
        step();
        commit = 1'b0; tick = 1'b0;
        expect_at(1, K_PENDING, 0, 32'h0, "ct_pending_after");
        step();

        // Apply edge coinciding with a fresh trig on slot 2
        data_hi = 16'h2222; data_lo = 16'h2222; trig = 8'h04;
        step();
        trig = '0; commit = 1'b1;
        step();
        commit = 1'b0; tick = 1'b1; trig = 8'h04; data_hi = 16'h1111; data_lo = 16'h1111;
        expect_at(1, K_PARAM, 2, 32'h22222222, "co_active2");
        expect_at(1, K_DIRTY, 2, 32'h1, "co_dirty2");
        expect_upd(1);
        step();
        tick = 1'b0; trig = '0; rd_sel = 5'd2; rd_shadow = 1'b1;
        expect_at(1, K_RD, 0, 32'h11111111, "co_shadow2_rd");
        step();
        rd_shadow = 1'b0;
        expect_at(1, K_RD, 0, 32'h22222222, "co_active2_rd");
        step();

        // Reset while armed with slot 4 staged
        data_hi = 16'h4444; data_lo = 16'h4444; trig = 8'h10;
        step();
        trig = '0; commit = 1'b1;
        step();
        commit = 1'b0;
        expect_at(0, K_PENDING, 0, 32'h1, "ra_pending_armed");
        step();
        reset = 1'b1;
        expect_at(0, K_PARAM, 4, 32'hD0000004, "ra_slot4_def");
        expect_at(0, K_PARAM, 2, 32'hD0000002, "ra_slot2_def");
        expect_at(0, K_PENDING, 0, 32'h0, "ra_pending_clr");
        expect_at(0, K_DIRTY, 4, 32'h0, "ra_dirty4_clr");
        expect_at(0, K_RD, 0, 32'h0, "ra_rd_clr");
        step();
        reset = 1'b0;
        step();
        tick = 1'b1;
        expect_at(1, K_PARAM, 4, 32'hD0000004, "ra_tick_slot4");
        expect_at(1, K_PENDING, 0, 32'h0, "ra_tick_pending");
        step();
        tick = 1'b0;

        // Readback range and source selection
        rd_sel = 5'd1; rd_shadow = 1'b0;
        expect_at(1, K_RD, 0, 32'hD0000001, "rd_slot1");
        step();
        rd_sel = 5'(NP);
        expect_at(1, K_RD, 0, 32'h0, "rd_sel_np");
        step();
        data_hi = 16'hABCD; data_lo = 16'h0123; trig = 8'h08; rd_sel = 5'd31;
        expect_at(1, K_RD, 0, 32'h0, "rd_sel_31");
        step();
        trig = '0; rd_sel = 5'd3; rd_shadow = 1'b1;
        expect_at(1, K_RD, 0, 32'hABCD0123, "rd_shadow3");
        step();
        rd_shadow = 1'b0;
        expect_at(1, K_RD, 0, 32'hD0000003, "rd_active3");
        step();

        // Mode switch keeps slot dirty; immediate write clears it
        mode = 1'b0;
        expect_at(1, K_DIRTY, 3, 32'h1, "ms_dirty3_kept");
        expect_at(1, K_PARAM, 3, 32'hD0000003, "ms_slot3_kept");
        step();
        data_hi = 16'h5555; data_lo = 16'h5555; trig = 8'h08;
        expect_at(1, K_PARAM, 3, 32'h55555555, "ms_slot3_imm");
        expect_at(1, K_DIRTY, 3, 32'h0, "ms_dirty3_clr");
        expect_upd(1);
        step();
        trig = '0;

        // Commit with nothing staged; second commit while armed ignored
        commit = 1'b1;
        expect_at(1, K_PENDING, 0, 32'h1, "nc_arm");
        step();
        commit = 1'b0;
        expect_at(1, K_PENDING, 0, 32'h1, "nc_hold");
        step();
        commit = 1'b1;
        expect_at(1, K_PENDING, 0, 32'h1, "nc_recommit");
        step();
        commit = 1'b0; tick = 1'b1;
        expect_at(1, K_PENDING, 0, 32'h0, "nc_apply");
        step();
        tick = 1'b0;

        // soft_clr overrides trig and commit
        mode = 1'b1; data_hi = 16'h6666; data_lo = 16'h6666; trig = 8'h20;
        expect_at(1, K_DIRTY, 5, 32'h1, "sc_dirty5_set");
        step();
        soft_clr = 1'b1; mode = 1'b0; trig = 8'h01; commit = 1'b1;
        data_hi = 16'h7777; data_lo = 16'h7777;
        expect_at(1, K_PARAM, 0, 32'hD0000000, "sc_slot0_def");
        expect_at(1, K_PARAM, 3, 32'hD0000003, "sc_slot3_def");
        expect_at(1, K_DIRTY, 5, 32'h0, "sc_dirty5_clr");
        expect_at(1, K_PENDING, 0, 32'h0, "sc_pending");
        expect_upd(1);
        step();
        soft_clr = 1'b0; trig = '0; commit = 1'b0; tick = 1'b1; rd_sel = 5'd5; rd_shadow = 1'b1;
        expect_at(1, K_PARAM, 5, 32'hD0000005, "sc_slot5_def");
        expect_at(1, K_RD, 0, 32'hD0000005, "sc_shadow5_def");
        expect_at(1, K_PENDING, 0, 32'h0, "sc_pending_after");
        step();
        tick = 1'b0;

        repeat (3) step();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s got=unchecked want=%h (due cyc %0d)", e.name, e.val, e.cyc);
        end
        while (updq.size() > 0) begin
            int w;
            w = updq.pop_front();
            checks++;
            errors++;
            $display("FAIL upd_missing got=0 want=1 (due cyc %0d)", w);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
